// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx: PS/2 keyboard device-to-host frame receiver.
//   Synchronises the raw PS/2 pins, deserialises 11-bit frames (start, 8 data
//   LSB first, odd parity, stop), folds E0/F0 prefix bytes into ext/brk flags
//   and queues completed scancodes in a first-word-fall-through FIFO.
//
// Ports:
//   clk        in   system clock (25 MHz nominal)
//   resetn     in   synchronous active-low reset
//   kbd_clk    in   raw PS/2 clock pin (asynchronous)
//   kbd_data   in   raw PS/2 data pin (asynchronous)
//   out_code   out  scancode at the FIFO head
//   out_ext    out  head code was preceded by E0
//   out_brk    out  head code was preceded by F0 (key release)
//   out_valid  out  FIFO not empty
//   out_ready  in   consumer accepts the head entry
//   err        out  one-cycle pulse on parity, stop or timeout error
//   ovf        out  one-cycle pulse when a completed code is dropped (FIFO full)
//
// Build option:
//   PS2_TIMEOUT_EN  when defined, a partial frame is abandoned (with err) after
//                   TIMEOUT_CYCLES clk cycles without a KBD_CLK falling edge.

module ps2_kbd_rx #(
    parameter int unsigned TIMEOUT_CYCLES = 2500,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       kbd_clk,
    input  logic       kbd_data,
    output logic [7:0] out_code,
    output logic       out_ext,
    output logic       out_brk,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       err,
    output logic       ovf
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned EW = 10;

    // Elaboration-time parameter sanity checks
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("ps2_kbd_rx: FIFO_DEPTH must be a power of two and at least 2");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("ps2_kbd_rx: TIMEOUT_CYCLES must be at least 2");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Pin synchronisers and falling-edge detect
    // ------------------------------------------------------------------
    logic r_clk_s1, r_clk_s2, r_clk_prev;
    logic r_data_s1, r_data_s2;
    logic r_fall;       // registered KBD_CLK falling-edge strobe
    logic r_data_smp;   // data delayed to line up with r_fall

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_clk_prev <= 1'b1;
            r_data_s1  <= 1'b1;
            r_data_s2  <= 1'b1;
            r_fall     <= 1'b0;
            r_data_smp <= 1'b1;
        end else begin
            r_clk_s1   <= kbd_clk;
            r_clk_s2   <= r_clk_s1;
            r_clk_prev <= r_clk_s2;
            r_data_s1  <= kbd_data;
            r_data_s2  <= r_data_s1;
            r_fall     <= r_clk_prev & ~r_clk_s2;
            r_data_smp <= r_data_s2;
        end
    end

    // ------------------------------------------------------------------
    // Frame state machine: state register
    // ------------------------------------------------------------------
    state_t     r_state;
    logic [7:0] r_shift;
    logic [2:0] r_bit_cnt;
    logic       r_par;
    logic       r_par_ok;
    logic       r_ext;
    logic       r_brk;
    logic       r_err;

    state_t     w_state_nxt;
    logic [7:0] w_shift_nxt;
    logic [2:0] w_bit_cnt_nxt;
    logic       w_par_nxt;
    logic       w_par_ok_nxt;
    logic       w_ext_nxt;
    logic       w_brk_nxt;
    logic       w_err_nxt;
    logic       w_push;

`ifdef PS2_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TW-1:0] r_to_cnt;
    logic [TW-1:0] w_to_cnt_nxt;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_shift   <= 8'h00;
            r_bit_cnt <= 3'd0;
            r_par     <= 1'b0;
            r_par_ok  <= 1'b0;
            r_ext     <= 1'b0;
            r_brk     <= 1'b0;
            r_err     <= 1'b0;
`ifdef PS2_TIMEOUT_EN
            r_to_cnt  <= '0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_par     <= w_par_nxt;
            r_par_ok  <= w_par_ok_nxt;
            r_ext     <= w_ext_nxt;
            r_brk     <= w_brk_nxt;
            r_err     <= w_err_nxt;
`ifdef PS2_TIMEOUT_EN
            r_to_cnt  <= w_to_cnt_nxt;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Frame state machine: next state, prefix folding, push request
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_bit_cnt_nxt = r_bit_cnt;
        w_par_nxt     = r_par;
        w_par_ok_nxt  = r_par_ok;
        w_ext_nxt     = r_ext;
        w_brk_nxt     = r_brk;
        w_err_nxt     = 1'b0;
        w_push        = 1'b0;
`ifdef PS2_TIMEOUT_EN
        w_to_cnt_nxt  = r_to_cnt;
`endif

        case (r_state)
            S_IDLE: begin
                // Only a sampled 0 is a start bit; a 1 is line noise
                if (r_fall && !r_data_smp) begin
                    w_state_nxt   = S_DATA;
                    w_bit_cnt_nxt = 3'd0;
                    w_par_nxt     = 1'b0;
                end
            end
            S_DATA: begin
                if (r_fall) begin
                    w_shift_nxt = {r_data_smp, r_shift[7:1]};
                    w_par_nxt   = r_par ^ r_data_smp;
                    if (r_bit_cnt == 3'd7) begin
                        w_state_nxt = S_PARITY;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                // Odd parity: data ones plus parity bit must be odd
                if (r_fall) begin
                    w_par_ok_nxt = r_par ^ r_data_smp;
                    w_state_nxt  = S_STOP;
                end
            end
            S_STOP: begin
                if (r_fall) begin
                    w_state_nxt = S_IDLE;
                    if (r_data_smp && r_par_ok) begin
                        if (r_shift == 8'hE0) begin
                            w_ext_nxt = 1'b1;
                        end else if (r_shift == 8'hF0) begin
                            w_brk_nxt = 1'b1;
                        end else begin
                            w_push    = 1'b1;
                            w_ext_nxt = 1'b0;
                            w_brk_nxt = 1'b0;
                        end
                    end else begin
                        w_err_nxt = 1'b1;
                        w_ext_nxt = 1'b0;
                        w_brk_nxt = 1'b0;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

`ifdef PS2_TIMEOUT_EN
        // Watchdog on a partial frame; any falling edge restarts it
        if (r_state == S_IDLE || r_fall) begin
            w_to_cnt_nxt = '0;
        end else if (r_to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            w_state_nxt  = S_IDLE;
            w_err_nxt    = 1'b1;
            w_ext_nxt    = 1'b0;
            w_brk_nxt    = 1'b0;
            w_to_cnt_nxt = '0;
        end else begin
            w_to_cnt_nxt = r_to_cnt + TW'(1);
        end
`endif
    end

    // ------------------------------------------------------------------
    // Output FIFO (first-word-fall-through); pointer MSB separates full/empty
    // ------------------------------------------------------------------
    logic [EW-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic          r_ovf;

    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_do_push;
    logic [EW-1:0] w_head;

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop     = !w_empty && out_ready;
    // A pop in the same cycle frees the slot for a push into a full FIFO
    assign w_do_push = w_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_ovf    <= 1'b0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= {r_ext, r_brk, r_shift};
                r_wr_ptr                <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_ovf <= w_push && w_full && !w_pop;
        end
    end

    assign w_head    = r_mem[r_rd_ptr[AW-1:0]];
    assign out_code  = w_head[7:0];
    assign out_brk   = w_head[8];
    assign out_ext   = w_head[9];
    assign out_valid = !w_empty;
    assign err       = r_err;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// tb_ps2_kbd_rx: directed self-checking bench for ps2_kbd_rx.
//   Drives PS/2 frames bit by bit on the raw pins and checks FIFO contents,
//   prefix flags, error/overflow pulses, latency and reset behaviour.

module tb_ps2_kbd_rx;

    localparam int T = 300;   // TIMEOUT_CYCLES used for the DUT
    localparam int H = 40;    // PS/2 half bit period in clk cycles

    logic       clk;
    logic       resetn;
    logic       kbd_clk;
    logic       kbd_data;
    logic [7:0] out_code;
    logic       out_ext;
    logic       out_brk;
    logic       out_valid;
    logic       out_ready;
    logic       err;
    logic       ovf;

    int checks;
    int errors;
    int cyc;
    int err_cnt;
    int ovf_cnt;
    int g_lat;
    int last_fall_cyc;

    ps2_kbd_rx #(
        .TIMEOUT_CYCLES (T),
        .FIFO_DEPTH     (4)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .kbd_clk   (kbd_clk),
        .kbd_data  (kbd_data),
        .out_code  (out_code),
        .out_ext   (out_ext),
        .out_brk   (out_brk),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse counters sampled mid-cycle
    initial begin
        err_cnt = 0;
        ovf_cnt = 0;
    end
    always @(negedge clk) begin
        if (err) err_cnt <= err_cnt + 1;
        if (ovf) ovf_cnt <= ovf_cnt + 1;
    end

    // One PS/2 bit: data set up half a period before the clock falls
    task automatic ps2_bit(input logic b);
        @(posedge clk); #1 kbd_data = b;
        repeat (H) @(posedge clk);
        #1 kbd_clk = 1'b0;
        last_fall_cyc = cyc;
        repeat (H) @(posedge clk);
        #1 kbd_clk = 1'b1;
    endtask

    // Full frame; the stop bit is driven inline to measure latency and
    // optionally assert out_ready exactly in the push cycle
    task automatic send_frame(input logic [7:0] code, input logic bad_par,
                              input logic stop_val, input logic pop_at_push);
        logic v0;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(code[i]);
        ps2_bit((~^code) ^ bad_par);
        @(posedge clk); #1 kbd_data = stop_val;
        repeat (H) @(posedge clk);
        #1 kbd_clk = 1'b0;
        v0    = out_valid;
        g_lat = 0;
        for (int k = 1; k <= H; k++) begin
            @(posedge clk); #1;
            out_ready = (k == 3) && pop_at_push;
            if (g_lat == 0 && !v0 && out_valid) g_lat = k;
        end
        kbd_clk  = 1'b1;
        kbd_data = 1'b1;
        repeat (H) @(posedge clk);
        #1;
    endtask

    task automatic pop_one();
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        resetn    = 1'b0;
        kbd_clk   = 1'b1;
        kbd_data  = 1'b1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        checks++;
        if ({out_ext, out_brk, out_code} !== 10'h000) begin
            errors++; $display("FAIL reset_head: got %h expected 000", {out_ext, out_brk, out_code});
        end
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
        checks++;
        if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
        resetn = 1'b1;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int e0;
        e0 = err_cnt;
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        checks++;
        if (g_lat != 4) begin errors++; $display("FAIL basic_latency: got %0d expected 4", g_lat); end
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", out_valid); end
        checks++;
        if ({out_ext, out_brk, out_code} !== 10'h01C) begin
            errors++; $display("FAIL basic_head: got %h expected 01c", {out_ext, out_brk, out_code});
        end
        checks++;
        if (err_cnt != e0) begin errors++; $display("FAIL basic_err: got %0d pulses expected 0", err_cnt - e0); end
        pop_one();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_single: got valid %b expected 0", out_valid); end
        // Ready while empty must not move the read pointer
        pop_one();
        pop_one();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL empty_ready: got valid %b expected 0", out_valid); end
    endtask

    task automatic test_prefix();
        send_frame(8'hE0, 1'b0, 1'b1, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
        send_frame(8'h75, 1'b0, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || {out_ext, out_brk, out_code} !== 10'h375) begin
            errors++; $display("FAIL prefix_head: got v=%b %h expected v=1 375", out_valid, {out_ext, out_brk, out_code});
        end
        pop_one();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL prefix_single: got valid %b expected 0", out_valid); end
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || {out_ext, out_brk, out_code} !== 10'h01C) begin
            errors++; $display("FAIL prefix_cleared: got v=%b %h expected v=1 01c", out_valid, {out_ext, out_brk, out_code});
        end
        pop_one();
    endtask

    task automatic test_frame_errors();
        int e0;
        e0 = err_cnt;
        send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
        checks++;
        if (err_cnt != e0 + 1) begin errors++; $display("FAIL parity_err: got %0d pulses expected 1", err_cnt - e0); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL parity_drop: got valid %b expected 0", out_valid); end
        send_frame(8'h32, 1'b0, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || {out_ext, out_brk, out_code} !== 10'h032) begin
            errors++; $display("FAIL parity_recover: got v=%b %h expected v=1 032", out_valid, {out_ext, out_brk, out_code});
        end
        pop_one();
        // Bad stop bit after an E0 prefix: error, and the prefix is discarded
        e0 = err_cnt;
        send_frame(8'hE0, 1'b0, 1'b1, 1'b0);
        send_frame(8'h45, 1'b0, 1'b0, 1'b0);
        checks++;
        if (err_cnt != e0 + 1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL stop_err: got %0d pulses v=%b expected 1 pulse v=0", err_cnt - e0, out_valid);
        end
        send_frame(8'h11, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({out_ext, out_brk, out_code} !== 10'h011) begin
            errors++; $display("FAIL stop_prefix_clear: got %h expected 011", {out_ext, out_brk, out_code});
        end
        pop_one();
    endtask

    task automatic test_back_to_back();
        int o0;
        logic [7:0] exp;
        o0 = ovf_cnt;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, 1'b1, 1'b0);
        checks++;
        if (ovf_cnt != o0 + 1) begin errors++; $display("FAIL ovf_pulse: got %0d pulses expected 1", ovf_cnt - o0); end
        for (int i = 1; i <= 4; i++) begin
            exp = 8'(i);
            checks++;
            if (out_valid !== 1'b1 || out_code !== exp) begin
                errors++; $display("FAIL ovf_order: got v=%b %h expected v=1 %h", out_valid, out_code, exp);
            end
            pop_one();
        end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL ovf_drain: got valid %b expected 0", out_valid); end

        // Full FIFO, push coincides with a pop: accepted, no overflow
        o0 = ovf_cnt;
        for (int i = 0; i < 4; i++) send_frame(8'h11 + 8'(i), 1'b0, 1'b1, 1'b0);
        send_frame(8'h15, 1'b0, 1'b1, 1'b1);
        checks++;
        if (ovf_cnt != o0) begin errors++; $display("FAIL full_pushpop_ovf: got %0d pulses expected 0", ovf_cnt - o0); end
        for (int i = 0; i < 4; i++) begin
            exp = 8'h12 + 8'(i);
            checks++;
            if (out_valid !== 1'b1 || out_code !== exp) begin
                errors++; $display("FAIL full_pushpop_order: got v=%b %h expected v=1 %h", out_valid, out_code, exp);
            end
            pop_one();
        end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL full_pushpop_drain: got valid %b expected 0", out_valid); end
    endtask

`ifdef PS2_TIMEOUT_EN
    task automatic test_timeout();
        int e0;
        int t0;
        int d;
        bit seen;
        e0   = err_cnt;
        seen = 1'b0;
        d    = 0;
        ps2_bit(1'b0);
        ps2_bit(1'b0);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b1);
        t0 = last_fall_cyc;
        for (int k = 0; k < T + 50; k++) begin
            @(posedge clk); #1;
            if (err) begin
                seen = 1'b1;
                d    = cyc - t0;
                break;
            end
        end
        checks++;
        if (!seen || d != T + 4) begin
            errors++; $display("FAIL timeout_delay: got seen=%b delay=%0d expected seen=1 delay=%0d", seen, d, T + 4);
        end
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (err_cnt != e0 + 1) begin errors++; $display("FAIL timeout_pulses: got %0d expected 1", err_cnt - e0); end
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || {out_ext, out_brk, out_code} !== 10'h01C) begin
            errors++; $display("FAIL timeout_recover: got v=%b %h expected v=1 01c", out_valid, {out_ext, out_brk, out_code});
        end
        pop_one();
    endtask
`else
    task automatic test_no_timeout();
        int e0;
        e0 = err_cnt;
        // 0x1C sent with a long stall after the low nibble
        ps2_bit(1'b0);
        ps2_bit(1'b0);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b1);
        repeat (3 * T) @(posedge clk);
        #1;
        checks++;
        if (err_cnt != e0) begin errors++; $display("FAIL stall_err: got %0d pulses expected 0", err_cnt - e0); end
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b0);
        ps2_bit(1'b0);
        ps2_bit(1'b0);   // parity: three ones in 0x1C
        ps2_bit(1'b1);   // stop
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || {out_ext, out_brk, out_code} !== 10'h01C || err_cnt != e0) begin
            errors++; $display("FAIL stall_resume: got v=%b %h errs=%0d expected v=1 01c errs=0",
                               out_valid, {out_ext, out_brk, out_code}, err_cnt - e0);
        end
        pop_one();
    endtask
`endif

    task automatic test_reset_midframe();
        int e0;
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_queued: got valid %b expected 1", out_valid); end
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        e0 = err_cnt;
        @(posedge clk); #1 resetn = 1'b0;
        @(posedge clk); #1 resetn = 1'b1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_flush: got valid %b expected 0", out_valid); end
        repeat (2 * T) @(posedge clk);
        #1;
        checks++;
        if (err_cnt != e0) begin errors++; $display("FAIL rst_no_err: got %0d pulses expected 0", err_cnt - e0); end
        send_frame(8'h29, 1'b0, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || {out_ext, out_brk, out_code} !== 10'h029) begin
            errors++; $display("FAIL rst_next: got v=%b %h expected v=1 029", out_valid, {out_ext, out_brk, out_code});
        end
        pop_one();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_single: got valid %b expected 0", out_valid); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        g_lat  = 0;
        last_fall_cyc = 0;
        test_reset();
        test_basic();
        test_prefix();
        test_frame_errors();
        test_back_to_back();
`ifdef PS2_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Run-time bound
    initial begin
        #5ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
